// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: opcode, flag bundle and
// the stage-count helper used to size the pipeline.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBB = 2'd3
    } op_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    function automatic int unsigned addsub_lat(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    localparam int unsigned ADDSUB_DEFAULT_LAT = addsub_lat(32, 8);

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand and result handshake bundle between register-read, the add/sub
// pipeline and writeback.
interface addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    import addsub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    op_t              Op;
    logic             Cin;
    logic             Saturate;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    flags_t           Flags;

    modport slave (
        input  in_valid, A, B, Op, Cin, Saturate, out_ready,
        output in_ready, out_valid, Result, Flags
    );

    modport master (
        output in_valid, A, B, Op, Cin, Saturate, out_ready,
        input  in_ready, out_valid, Result, Flags
    );

endinterface

// File: rtl/addsub_chunk.sv
// One CHUNK-bit combinational adder slice; the pipeline chains one per stage
// through registered carries.
module addsub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with C/V/Z/N flags and optional signed saturation;
// one CHUNK-bit slice per stage, whole pipe freezes on output backpressure.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_pipe_if.slave  bus
);

    localparam int unsigned LAT = addsub_lat(WIDTH, CHUNK);
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] b_sel;
    logic             c0;
    logic             stall;

    // _s: stage inputs, _d: stage outputs, _q: stage registers
    logic             vld_s [LAT];
    logic             cy_s  [LAT];
    logic             sat_s [LAT];
    logic             am_s  [LAT];
    logic             bm_s  [LAT];
    logic [WIDTH-1:0] a_s   [LAT];
    logic [WIDTH-1:0] b_s   [LAT];
    logic [WIDTH-1:0] res_s [LAT];

    logic [CHUNK-1:0] sum_w [LAT];
    logic             cy_d  [LAT];
    logic [WIDTH-1:0] a_d   [LAT];
    logic [WIDTH-1:0] b_d   [LAT];
    logic [WIDTH-1:0] res_d [LAT];

    logic             vld_q [LAT];
    logic             cy_q  [LAT];
    logic             sat_q [LAT];
    logic             am_q  [LAT];
    logic             bm_q  [LAT];
    logic [WIDTH-1:0] a_q   [LAT];
    logic [WIDTH-1:0] b_q   [LAT];
    logic [WIDTH-1:0] res_q [LAT];

    logic             ovf;
    logic [WIDTH-1:0] fin_d;
    flags_t           flags_d;
    flags_t           flags_q;

    always_comb begin
        b_sel = bus.B;
        c0    = 1'b0;
        case (bus.Op)
            ADD: c0 = 1'b0;
            SUB: begin
                b_sel = ~bus.B;
                c0    = 1'b1;
            end
            ADC: c0 = bus.Cin;
            SBB: begin
                b_sel = ~bus.B;
                c0    = bus.Cin;
            end
            default: c0 = 1'b0;
        endcase
    end

    // Skew registers shift right by CHUNK so each stage always consumes the
    // low slice; result chunks enter from the top and land in order.
    for (genvar k = 0; k < LAT; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign vld_s[k] = bus.in_valid;
            assign cy_s[k]  = c0;
            assign sat_s[k] = bus.Saturate;
            assign am_s[k]  = bus.A[WIDTH-1];
            assign bm_s[k]  = b_sel[WIDTH-1];
            assign a_s[k]   = bus.A;
            assign b_s[k]   = b_sel;
            assign res_s[k] = '0;
        end else begin : g_next
            assign vld_s[k] = vld_q[k-1];
            assign cy_s[k]  = cy_q[k-1];
            assign sat_s[k] = sat_q[k-1];
            assign am_s[k]  = am_q[k-1];
            assign bm_s[k]  = bm_q[k-1];
            assign a_s[k]   = a_q[k-1];
            assign b_s[k]   = b_q[k-1];
            assign res_s[k] = res_q[k-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_s[k][CHUNK-1:0]),
            .b    (b_s[k][CHUNK-1:0]),
            .cin  (cy_s[k]),
            .sum  (sum_w[k]),
            .cout (cy_d[k])
        );

        assign a_d[k]   = a_s[k] >> CHUNK;
        assign b_d[k]   = b_s[k] >> CHUNK;
        assign res_d[k] = (res_s[k] >> CHUNK) | (WIDTH'(sum_w[k]) << (WIDTH - CHUNK));
    end

    always_comb begin
        ovf   = (am_s[LAT-1] == bm_s[LAT-1]) && (res_d[LAT-1][WIDTH-1] != am_s[LAT-1]);
        fin_d = res_d[LAT-1];
        if (sat_s[LAT-1] && ovf) begin
            fin_d = am_s[LAT-1] ? SAT_NEG : SAT_POS;
        end
        flags_d.c = cy_d[LAT-1];
        flags_d.v = ovf;
        flags_d.z = (fin_d == '0);
        flags_d.n = fin_d[WIDTH-1];
    end

    assign stall         = vld_q[LAT-1] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld_q[LAT-1];
    assign bus.Result    = res_q[LAT-1];
    assign bus.Flags     = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                sat_q[k] <= 1'b0;
                am_q[k]  <= 1'b0;
                bm_q[k]  <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
            flags_q <= '0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                vld_q[k] <= vld_s[k];
                cy_q[k]  <= cy_d[k];
                sat_q[k] <= sat_s[k];
                am_q[k]  <= am_s[k];
                bm_q[k]  <= bm_s[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                res_q[k] <= (k == LAT - 1) ? fin_d : res_d[k];
            end
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against a signed-arithmetic model.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned LAT   = WIDTH / CHUNK;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors    = 0;
    int checks    = 0;
    int delivered = 0;
    int accepted  = 0;
    exp_t sb[$];
    logic        ov_seen;
    logic [31:0] res_seen;
    logic [3:0]  flg_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic cin, input logic sat);
        longint sa, sb_, ua, ub, ci, ex;
        logic c, v;
        logic [31:0] fin;
        exp_t e;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ci  = longint'({63'd0, cin});
        case (op)
            2'd0: begin ex = sa + sb_;          c = (ua + ub) >= 64'sd4294967296;      end
            2'd1: begin ex = sa - sb_;          c = ua >= ub;                          end
            2'd2: begin ex = sa + sb_ + ci;     c = (ua + ub + ci) >= 64'sd4294967296; end
            default: begin ex = sa - sb_ - (1 - ci); c = ua >= (ub + 1 - ci);          end
        endcase
        v   = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        fin = ex[31:0];
        if (sat && v) fin = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.r = fin;
        e.f = {c, v, (fin == 32'd0), fin[31]};
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic cin, input logic sat);
        bus.A        = a;
        bus.B        = b;
        bus.Op       = op_t'(op);
        bus.Cin      = cin;
        bus.Saturate = sat;
    endtask

    task automatic drive_random();
        drive(rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Samples the settled cycle, scores delivery/acceptance, then advances one edge.
    task automatic tick();
        exp_t e;
        #1;
        ov_seen  = bus.out_valid;
        res_seen = bus.Result;
        flg_seen = bus.Flags;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(bus.out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("result", 64'(bus.Result), 64'(e.r));
                chk("flags", 64'(bus.Flags), 64'(e.f));
                delivered++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.A, bus.B, bus.Op, bus.Cin, bus.Saturate));
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic cin, input logic sat,
                              input logic [31:0] er, input logic [3:0] ef);
        int lat;
        drive(a, b, op, cin, sat);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ov_seen && lat < 20);
        chk({tag, "_latency"}, 64'(lat), 64'(LAT));
        chk({tag, "_result"}, 64'(res_seen), 64'(er));
        chk({tag, "_flags"}, 64'(flg_seen), 64'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_del, prev_acc, total;
        logic [31:0] held;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(32'd0, 32'd0, 2'd0, 1'b0, 1'b0);

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'(bus.Result), 64'(0));
        chk("rst_flags", 64'(bus.Flags), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed corner cases (flags as {C,V,Z,N})
        run_single("add_carry",   32'h0000_00FF, 32'h0000_0001, 2'd0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000);
        run_single("sub_zero",    32'd5,         32'd5,         2'd1, 1'b0, 1'b0, 32'h0000_0000, 4'b1010);
        run_single("sub_borrow",  32'd0,         32'd1,         2'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0001);
        run_single("add_sat",     32'h7FFF_FFFF, 32'd1,         2'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
        run_single("add_nosat",   32'h7FFF_FFFF, 32'd1,         2'd0, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
        run_single("sub_sat",     32'h8000_0000, 32'd1,         2'd1, 1'b0, 1'b1, 32'h8000_0000, 4'b1101);
        run_single("adc_cin",     32'hFFFF_FFFF, 32'd0,         2'd2, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);
        run_single("sbb_nocin",   32'd5,         32'd3,         2'd3, 1'b0, 1'b0, 32'h0000_0001, 4'b1000);

        // Backpressure: 8 beats, consumer stalls in cycles 5..7
        base_acc = accepted;
        base_del = delivered;
        total    = 0;
        held     = '0;
        drive_random();
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = !(c >= 5 && c <= 7);
            bus.in_valid  = (accepted - base_acc) < 8;
            #1;
            chk("bp_in_ready", 64'(bus.in_ready), (c >= 5 && c <= 7) ? 64'(0) : 64'(1));
            if (c == 5) held = bus.Result;
            if (c >= 6 && c <= 8) chk("bp_hold", 64'(bus.Result), 64'(held));
            prev_acc = accepted;
            tick();
            if (accepted != prev_acc) drive_random();
            if (delivered - base_del == 8) begin
                total = c + 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_total_cycles", 64'(total), 64'(8 + LAT + 3));
        chk("bp_count", 64'(delivered - base_del), 64'(8));

        // Randomized traffic with random valid/ready
        drive_random();
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            prev_acc = accepted;
            tick();
            if (accepted != prev_acc) drive_random();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'(0));

        // Reset with three beats in flight
        for (int j = 0; j < 3; j++) begin
            drive_random();
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_result", 64'(bus.Result), 64'(0));
        chk("midrst_flags", 64'(bus.Flags), 64'(0));
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_idle", 64'(ov_seen), 64'(0));
        end
        run_single("post_rst", 32'h1234_5678, 32'h1111_1111, 2'd0, 1'b0, 1'b0, 32'h2345_6789, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
